// File: rtl/demux6_skid_pkg.sv
// Shared types and helpers for the demux6_skid steering block.
//   num_ch       : number of consumer channels
//   chan_sel_t   : 3-bit destination select
//   skid_state_t : occupancy of the two-entry skid buffer
//   sel_remap()  : folds the unused selects 6/7 onto channel 0
package demux_pkg;

  localparam int unsigned NUM_CH = 6;

  typedef logic [2:0] chan_sel_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } skid_state_t;

  // Selects 6 and 7 have no channel; route them where the 6:1 mux default arm would.
  function automatic chan_sel_t sel_remap(chan_sel_t sel);
    if (sel >= chan_sel_t'(NUM_CH)) begin
      return chan_sel_t'(0);
    end
    return sel;
  endfunction

  function automatic logic sel_is_bad(chan_sel_t sel);
    return (sel >= chan_sel_t'(NUM_CH));
  endfunction

endpackage

// File: rtl/demux6_skid_if.sv
// Stream bundle between a producer, demux6_skid and its six consumers.
//   in_valid/in_ready/in_data/in_sel : producer-side handshake and beat
//   out_valid/out_ready/out_data     : per-channel valid/ready, shared payload
//   bad_sel                          : pulse after a beat with select 6/7 was taken
// modport slave  : the demux itself
// modport master : the surrounding producer/consumer logic
interface demux6_skid_if #(
  parameter int unsigned WIDTH = 32
);
  import demux_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_data;
  chan_sel_t         in_sel;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic [WIDTH-1:0]  out_data;
  logic              bad_sel;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_sel,
    output out_valid,
    input  out_ready,
    output out_data,
    output bad_sel
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_sel,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  bad_sel
  );

endinterface

// File: rtl/demux6_skid_dec6_onehot.sv
// Combinational 3-to-6 one-hot decoder with enable.
//   en     : when low the output is all zeros
//   sel    : channel index; 6 and 7 decode to zero
//   onehot : one-hot channel vector
module dec6_onehot
  import demux_pkg::*;
(
  input  logic              en,
  input  chan_sel_t         sel,
  output logic [NUM_CH-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      case (sel)
        3'd0:    onehot = 6'b000001;
        3'd1:    onehot = 6'b000010;
        3'd2:    onehot = 6'b000100;
        3'd3:    onehot = 6'b001000;
        3'd4:    onehot = 6'b010000;
        3'd5:    onehot = 6'b100000;
        default: onehot = '0;
      endcase
    end
  end

endmodule

// File: rtl/demux6_skid.sv
// Registered 1-to-6 steering block with a two-entry skid buffer.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   flush : synchronous flush; drops every buffered and in-flight beat
//   bus   : stream bundle (slave view): in_valid/in_ready/in_data/in_sel in,
//           out_valid[5:0]/out_ready[5:0]/out_data out, bad_sel pulse
// The main entry drives the outputs; the skid entry absorbs the beat accepted
// while the head is stalled, so in_ready can be a register.
module demux6_skid
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  demux6_skid_if.slave  bus
);

  skid_state_t      state;
  logic [WIDTH-1:0] main_data;
  chan_sel_t        main_sel;
  logic             main_valid;
  logic [WIDTH-1:0] skid_data;
  chan_sel_t        skid_sel;
  logic             skid_valid;
  logic             in_ready_q;
  logic             bad_sel_q;

  logic              in_fire;
  logic              out_fire;
  logic [NUM_CH-1:0] main_onehot;
  chan_sel_t         in_sel_mapped;

  dec6_onehot u_dec (
    .en     (main_valid),
    .sel    (main_sel),
    .onehot (main_onehot)
  );

  assign in_sel_mapped = sel_remap(bus.in_sel);
  assign in_fire       = bus.in_valid & in_ready_q;
  // Only the selected channel's ready matters; the decoder masks the rest.
  assign out_fire      = |(main_onehot & bus.out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      main_data  <= '0;
      main_sel   <= '0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      bad_sel_q  <= 1'b0;
    end else if (flush) begin
      // Payload registers are left alone; valid bits alone make them dead.
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      bad_sel_q  <= 1'b0;
    end else begin
      bad_sel_q <= in_fire & sel_is_bad(bus.in_sel);
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data  <= bus.in_data;
            main_sel   <= in_sel_mapped;
            main_valid <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            skid_data  <= bus.in_data;
            skid_sel   <= in_sel_mapped;
            skid_valid <= 1'b1;
            in_ready_q <= 1'b0;
            state      <= FULL;
          end else if (!in_fire && out_fire) begin
            main_valid <= 1'b0;
            state      <= EMPTY;
          end else if (in_fire && out_fire) begin
            main_data <= bus.in_data;
            main_sel  <= in_sel_mapped;
          end
        end
        FULL: begin
          // in_ready is low here, so no beat can arrive alongside the drain.
          if (out_fire) begin
            main_data  <= skid_data;
            main_sel   <= skid_sel;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          in_ready_q <= 1'b1;
          state      <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_onehot;
  assign bus.out_data  = main_data;
  assign bus.bad_sel   = bad_sel_q;

endmodule
